hex_scan_driver: RTL and testbench
==================================

# hex_scan_driver

Time-multiplexed, parametrised seven-segment display controller driving NUM_DIGITS common-anode digits from one shared active-low segment bus. It holds a loadable display register, scans one digit per refresh period, and decodes the full hex range 0–F. It also supports optional leading-zero blanking and per-digit blinking. It sits between datapath results (counters, ALU outputs) and the board's segment/anode pins and replaces one-decoder-per-digit wiring.

## Interface
- NUM_DIGITS, 4, number of scanned digits; legal range 1–8.
- REFRESH_DIV, 50000, clk cycles each digit is held active; must be ≥1.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be ≥1.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex digits; digit i is value[4i+3:4i], and digit 0 is least significant.
- load  in  1  captures value into the display register on the rising edge.
- blank_lz  in  1  enables leading-zero blanking when set.
- blink_mask  in  NUM_DIGITS  bit i set makes digit i blink.
- seg  out  7  segments {g,f,e,d,c,b,a}; active low.
- an  out  NUM_DIGITS  digit selects; active low, with exactly one bit low outside reset.

## Operation
- **Display register (disp_q):**
  - On reset, clears to 0.
  - When load=1, disp_q ← value. Otherwise it holds.
- **Refresh counter:**
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, scan index idx advances: idx+1, or 0 after NUM_DIGITS-1.
  - With REFRESH_DIV=1, idx advances every cycle.
- **Blink counter:**
  - Counts 0..BLINK_DIV-1.
  - At terminal count, blink_phase toggles. blink_phase=0 means visible.
  - Runs independently of the refresh counter.
- **Decode (hex_seg_decode):**
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0011000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110
  - Any x/z input decodes to 1111111 (blank).
- **Blank conditions for digit i.** Digit i is blanked when either condition holds:
  - Leading zero: blank_lz=1, i≠0, and digits i..NUM_DIGITS-1 of disp_q are all 0. Digit 0 is never blanked by this rule.
  - Blink: blink_mask[i]=1 and blink_phase=1.
- **Blanked digit output:** seg=1111111 while an still selects the digit, so scan timing is unchanged.
- **Registered outputs:** an ← ~(1<<idx); seg ← decoded or blanked pattern for disp_q digit idx.
- **No handshake:** load is a single-cycle strobe. Holding it high reloads on every cycle.

## Timing
- **During reset:** an=all 1s, seg=1111111, idx=0, both counters=0, blink_phase=0, disp_q=0.
- **First edge after reset deasserts:** an=~1, seg=1000000 (digit 0 shows '0').
- **Load latency:** load sampled at edge n updates disp_q at edge n. seg reflects the new value at edge n+1 whenever idx points at the changed digit.
- **Scan latency:** idx changes at edge n; an and seg show the new digit at edge n+1. an and seg always change on the same edge, so there is never a stale segment on a new anode.
- **Load and advance in the same cycle:** the next output uses both the new disp_q and the new idx.
- **Reset mid-scan:** behaves as a full restart on the next edge, with no partial retention of disp_q.
- **Blanking inputs:** blank_lz and blink_mask are sampled combinationally into the registered outputs, with one-cycle latency.
- **Counter widths:** $clog2 of the divisor (minimum 1 bit). Counters use no arithmetic beyond increment and compare, with no overflow.

## Structure
- **Shared include seg7_defs.vh:**
  - SEG_0..SEG_F constants
  - SEG_BLANK = 7'b1111111
  - ACTIVE_LOW note constants
- **Sub-module hex_seg_decode:** combinational, 4-bit digit in, 7-bit active-low pattern out. Instantiate once on the muxed digit.
- **Top-level (hex_scan_driver) contents:** disp_q, refresh and blink counters, idx, leading-zero mask generation, and the output registers.

## Test plan
- **Reset release:** NUM_DIGITS=4, REFRESH_DIV=4; hold reset 3 cycles, release → an=1110, seg=1000000 on the first edge; an steps 1101, 1011, 0111, 1110 every 4 cycles.
- **Full hex decode:** load value=16'hFEDC, then value=16'hBA98, and so on through all 16 codes → each digit shows the listed pattern when its anode is low; seg never changes on an edge where an does not.
- **Leading-zero blanking:** blank_lz=1, load 16'h0040 → digits 3 and 2 give 1111111, digit 1 gives 0011001, digit 0 gives 1000000. Load 16'h0000 → only digit 0 shows 1000000.
- **Blink:** BLINK_DIV=8, blink_mask=4'b0010, load 16'h1234 → digit 1 alternates 0110000 and 1111111 every 8 cycles; other digits are steady.
- **Load/advance collision and mid-scan reset:** assert load on the same cycle idx advances → the next output shows the new value. Reset asserted on an arbitrary cycle → the next edge gives an=1111 and seg=1111111. After release, the display shows all '0'.
- **Edge parameters:** NUM_DIGITS=1 with REFRESH_DIV=1 → an is constantly 0 and seg follows disp_q one cycle after load.

Source files
------------

// File: rtl/hex_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// hex_scan_driver_pkg
//
// Shared definitions for the multiplexed seven-segment driver:
//   - SEG_0 .. SEG_F : active-low {g,f,e,d,c,b,a} patterns for hex digits
//   - SEG_BLANK      : all segments off
//   - SEG_ON/SEG_OFF, AN_ON/AN_OFF : polarity reminders for the board pins
//   - cnt_width()    : counter width for a divisor (never less than 1 bit)
// ---------------------------------------------------------------------------
package hex_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    // Segments and anodes are both active low on this board.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;

    // Bit order is {g,f,e,d,c,b,a}.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0011000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Width of a counter running 0..div-1; a divisor of 1 still gets one
    // bit so the counter signal always exists.
    function automatic int cnt_width(input int div);
        if (div > 1) begin
            return $clog2(div);
        end
        return 1;
    endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// ---------------------------------------------------------------------------
// hex_scan_driver_if
//
// Groups the display-side signals of hex_scan_driver.
//   value      : packed hex digits, digit i = value[4i+3:4i]
//   load       : single-cycle strobe capturing value
//   blank_lz   : leading-zero blanking enable
//   blink_mask : per-digit blink enable
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   an         : active-low digit selects
//
// There is no valid/ready pair: load is a plain strobe that is accepted on
// every edge it is high, and seg/an are free-running registered outputs
// that the consumer may sample at any time.
//
// master : the datapath side driving the display (and observing the pins)
// slave  : the display driver itself
// ---------------------------------------------------------------------------
interface hex_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output value,
        output load,
        output blank_lz,
        output blink_mask,
        input  seg,
        input  an
    );

    modport slave (
        input  value,
        input  load,
        input  blank_lz,
        input  blink_mask,
        output seg,
        output an
    );
endinterface

// File: rtl/hex_scan_driver_hex_seg_decode.sv
// ---------------------------------------------------------------------------
// hex_seg_decode
//
// Combinational hex-to-seven-segment decoder.
//   digit : 4-bit hex value
//   seg   : active-low pattern {g,f,e,d,c,b,a}; unknown inputs give blank
// ---------------------------------------------------------------------------
module hex_seg_decode
    import hex_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            // x/z digits fall through to a dark digit rather than garbage.
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_driver.sv
// ---------------------------------------------------------------------------
// hex_scan_driver
//
// Time-multiplexed seven-segment controller for NUM_DIGITS common-anode
// digits sharing one active-low segment bus.
//
// Parameters:
//   NUM_DIGITS  : scanned digits (1..8)
//   REFRESH_DIV : clk cycles each digit stays selected (>= 1)
//   BLINK_DIV   : clk cycles per blink half-period (>= 1)
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : hex_scan_driver_if.slave (value, load, blank_lz, blink_mask
//           in; seg, an out)
//
// an and seg are both registered from the same idx/disp_q snapshot, so a
// new anode never appears with the previous digit's segments.
// ---------------------------------------------------------------------------
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    hex_scan_driver_if.slave bus
);

    localparam int RW = cnt_width(REFRESH_DIV);
    localparam int BW = cnt_width(BLINK_DIV);
    localparam int IW = cnt_width(NUM_DIGITS);

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] disp_q;
    logic [RW-1:0]           ref_cnt;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [IW-1:0]           idx;

    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;
    seg_t                    dec_seg;

    // Leading-zero mask: walk from the most significant digit down, keeping
    // a running "everything from here up is zero" flag. Digit 0 is always
    // shown so an all-zero value still displays a single '0'.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_q[4*i +: 4] == 4'h0);
            lz_mask[i] = bus.blank_lz && (i != 0) && zero_run;
        end
    end

    // Select the digit currently being scanned, plus its blank condition.
    always_comb begin
        cur_digit = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = disp_q[4*i +: 4];
                cur_blank = lz_mask[i] || (bus.blink_mask[i] && blink_phase);
            end
        end
    end

    // Single decoder shared by all digits, fed from the mux above.
    hex_seg_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q      <= '0;
            ref_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            idx         <= '0;
            bus.an      <= {NUM_DIGITS{AN_OFF}};
            bus.seg     <= SEG_BLANK;
        end else begin
            if (bus.load) begin
                disp_q <= bus.value;
            end

            // Refresh divider: idx moves on the cycle the counter wraps.
            // With REFRESH_DIV=1 the counter sits at its terminal count.
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            // Blink divider, independent of the scan.
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Outputs reflect the idx/disp_q values present before this
            // edge; a blanked digit keeps its anode so timing is uniform.
            bus.an  <= ~(NUM_DIGITS'(1) << idx);
            bus.seg <= cur_blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_hex_scan_driver
//
// Two instances run in lockstep: a 4-digit display with short dividers and
// a 1-digit display with REFRESH_DIV=1. Expected pins come from a model
// that derives the scanned digit and blink phase from the number of clock
// edges since reset using division, not from counter state.
// ---------------------------------------------------------------------------
module tb_hex_scan_driver;

    localparam int NA = 4;
    localparam int RA = 4;
    localparam int BA = 8;
    localparam int NB = 1;
    localparam int RB = 1;
    localparam int BB = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hex_scan_driver_if #(.NUM_DIGITS(NA)) if_a ();
    hex_scan_driver_if #(.NUM_DIGITS(NB)) if_b ();

    hex_scan_driver #(.NUM_DIGITS(NA), .REFRESH_DIV(RA), .BLINK_DIV(BA)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (if_a)
    );

    hex_scan_driver #(.NUM_DIGITS(NB), .REFRESH_DIV(RB), .BLINK_DIV(BB)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (if_b)
    );

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          k_a, k_b;       // edges since reset released
    logic [31:0] disp_a, disp_b; // model of the loaded display value
    int          n_tests;
    int          n_fail;
    int          cyc;

    // Returns {an (8 bits), seg (7 bits)} for the edge about to happen.
    function automatic logic [14:0] model_out(input int n, input int r, input int b,
                                              input int k, input logic [31:0] disp,
                                              input logic bl, input logic [7:0] mask);
        int          idx;
        int          ph;
        int          dig;
        logic [31:0] upper;
        logic        blank;
        logic [6:0]  s;
        logic [7:0]  a;
        idx   = (k / r) % n;
        ph    = (k / b) % 2;
        upper = disp >> (4 * idx);
        dig   = int'(upper & 32'hF);
        blank = (bl && idx != 0 && upper == 0) || (mask[idx] && ph == 1);
        s     = blank ? 7'h7F : seg_tab[dig];
        a     = 8'(((1 << n) - 1) & ~(1 << idx));
        return {a, s};
    endfunction

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock edge: predict both instances, clock, compare, advance model.
    task automatic tick();
        logic [14:0] ea, eb, got;
        if (rst) begin
            ea = {8'((1 << NA) - 1), 7'h7F};
            eb = {8'((1 << NB) - 1), 7'h7F};
        end else begin
            ea = model_out(NA, RA, BA, k_a, disp_a, if_a.blank_lz, 8'(if_a.blink_mask));
            eb = model_out(NB, RB, BB, k_b, disp_b, if_b.blank_lz, 8'(if_b.blink_mask));
        end
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        @(posedge clk);
        #1;
        cyc++;
        got = exp_q.pop_front();
        check_val("a_an",  32'(if_a.an),  32'(got[14:7]));
        check_val("a_seg", 32'(if_a.seg), 32'(got[6:0]));
        got = exp_q.pop_front();
        check_val("b_an",  32'(if_b.an),  32'(got[14:7]));
        check_val("b_seg", 32'(if_b.seg), 32'(got[6:0]));
        if (rst) begin
            k_a = 0; k_b = 0; disp_a = 0; disp_b = 0;
        end else begin
            if (if_a.load) disp_a = 32'(if_a.value);
            if (if_b.load) disp_b = 32'(if_b.value);
            k_a++;
            k_b++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] codes [0:3];
        n_tests = 0; n_fail = 0; cyc = 0;
        k_a = 0; k_b = 0; disp_a = 0; disp_b = 0;
        codes[0] = 16'hFEDC; codes[1] = 16'hBA98;
        codes[2] = 16'h7654; codes[3] = 16'h3210;

        rst = 1'b1;
        if_a.value = '0; if_a.load = 1'b0; if_a.blank_lz = 1'b0; if_a.blink_mask = '0;
        if_b.value = '0; if_b.load = 1'b0; if_b.blank_lz = 1'b0; if_b.blink_mask = '0;

        // Reset held 3 cycles, then a full free-running scan of zeros.
        run(3);
        rst = 1'b0;
        run(20);

        // Every hex code, each value held for a full scan.
        for (int c = 0; c < 4; c++) begin
            if_a.value = codes[c];
            if_a.load  = 1'b1;
            if_b.value = codes[c][3:0];
            if_b.load  = 1'b1;
            tick();
            if_a.load = 1'b0;
            if_b.load = 1'b0;
            run(17);
        end

        // Leading-zero blanking.
        if_a.blank_lz = 1'b1;
        if_a.value    = 16'h0040; if_a.load = 1'b1; tick(); if_a.load = 1'b0;
        run(17);
        if_a.value    = 16'h0000; if_a.load = 1'b1; tick(); if_a.load = 1'b0;
        run(17);
        if_a.blank_lz = 1'b0;

        // Blink on digit 1 only.
        if_a.blink_mask = 4'b0010;
        if_b.blink_mask = 1'b1;
        if_a.value = 16'h1234; if_a.load = 1'b1; tick(); if_a.load = 1'b0;
        run(40);
        if_a.blink_mask = '0;
        if_b.blink_mask = '0;

        // Load strobed on the cycle idx advances.
        for (int i = 0; i < 24; i++) begin
            if_a.value = 16'($urandom);
            if_a.load  = ((k_a % RA) == RA - 1);
            tick();
        end
        if_a.load = 1'b0;

        // Mid-scan reset, then all zeros again.
        run(int'($urandom_range(1, 7)));
        rst = 1'b1; tick(); rst = 1'b0;
        run(16);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            if_a.load       = ($urandom_range(0, 3) == 0);
            if_a.value      = 16'($urandom);
            if ($urandom_range(0, 1) == 0) if_a.value[15:8] = 8'h00;
            if_a.blank_lz   = 1'($urandom_range(0, 1));
            if_a.blink_mask = 4'($urandom);
            if_b.load       = ($urandom_range(0, 1) == 0);
            if_b.value      = 4'($urandom);
            if_b.blank_lz   = 1'($urandom_range(0, 1));
            if_b.blink_mask = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
